// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven_seg_scanner block.
//   state_e   : scanner FSM state encoding (IDLE, BLANK, DRIVE)
//   SEG_OFF   : segment pattern with every segment dark (active-low)
//   SEG_TABLE : hex digit -> active-low {g,f,e,d,c,b,a} pattern, entry n = digit n
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Packed so that SEG_TABLE[n] selects the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: data/control bundle between a display client and the scanner.
//   Tick, Load, Value, DigitEn, DpMask : client -> scanner
//   An, Seg, Dp, LoadAck, FrameDone    : scanner -> client / display pins
//   master modport: the client side; slave modport: the scanner.
interface seven_seg_scanner_if #(
  parameter int DIGITS = 8
);
  logic                  Tick;
  logic                  Load;
  logic [4*DIGITS-1:0]   Value;
  logic [DIGITS-1:0]     DigitEn;
  logic [DIGITS-1:0]     DpMask;
  logic [DIGITS-1:0]     An;
  logic [6:0]            Seg;
  logic                  Dp;
  logic                  LoadAck;
  logic                  FrameDone;

  modport master (
    output Tick, Load, Value, DigitEn, DpMask,
    input  An, Seg, Dp, LoadAck, FrameDone
  );

  modport slave (
    input  Tick, Load, Value, DigitEn, DpMask,
    output An, Seg, Dp, LoadAck, FrameDone
  );
endinterface

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a DIGITS-wide common-anode display.
//   Clk, Rst : clock and asynchronous active-high reset
//   bus      : slave side of seven_seg_scanner_if (Tick/Load/data in; An/Seg/Dp/
//              LoadAck/FrameDone out, all outputs registered and active-low for pins)
// Each Tick advances to the next digit; all anodes are held off for BLANK_CYCLES
// clocks afterwards to suppress ghosting. Loaded data waits in a pending buffer and
// only becomes visible when the digit index wraps to 0, so a frame never tears.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int BLANK_W      = 5
) (
  input  logic                Clk,
  input  logic                Rst,
  seven_seg_scanner_if.slave  bus
);
  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(DIGITS - 1);
  localparam logic [BLANK_W-1:0] BLANK_RELOAD = (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;
  localparam state_e             ADV_STATE    = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLANK_W-1:0]   cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  val_act_q, val_act_d, val_pend_q, val_pend_d;
  logic [DIGITS-1:0]    en_act_q, en_act_d, en_pend_q, en_pend_d;
  logic [DIGITS-1:0]    dp_act_q, dp_act_d, dp_pend_q, dp_pend_d;
  logic                 pend_flag_q, pend_flag_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 load_ack_q, load_ack_d;
  logic                 frame_done_q, frame_done_d;
  logic                 wrap;
  logic [3:0]           nibble_mux;
  logic [6:0]           seg_dec;

  assign wrap = bus.Tick && (idx_q == IDX_LAST);

  // Next-state: sequencing, blanking counter, load capture and frame-boundary commit.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    val_act_d    = val_act_q;
    en_act_d     = en_act_q;
    dp_act_d     = dp_act_q;
    val_pend_d   = val_pend_q;
    en_pend_d    = en_pend_q;
    dp_pend_d    = dp_pend_q;
    pend_flag_d  = pend_flag_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;

    // A Tick advances from any state, including mid-blank, so none is ever dropped.
    if (bus.Tick) begin
      idx_d        = wrap ? '0 : idx_q + 1'b1;
      state_d      = ADV_STATE;
      cnt_d        = BLANK_RELOAD;
      frame_done_d = wrap;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == '0) state_d = ST_DRIVE;
      else             cnt_d   = cnt_q - 1'b1;
    end

    // Commit uses the pending data held before this edge; a simultaneous Load
    // below refills the buffer and keeps the flag set for the next frame.
    if (wrap && pend_flag_q) begin
      val_act_d   = val_pend_q;
      en_act_d    = en_pend_q;
      dp_act_d    = dp_pend_q;
      pend_flag_d = 1'b0;
      load_ack_d  = 1'b1;
    end

    if (bus.Load) begin
      val_pend_d  = bus.Value;
      en_pend_d   = bus.DigitEn;
      dp_pend_d   = bus.DpMask;
      pend_flag_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state so the pins change on the same edge.
  assign nibble_mux = val_act_d[{idx_d, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_mux),
    .seg    (seg_dec)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      an_d[idx_d] = ~en_act_d[idx_d];
      seg_d       = seg_dec;
      dp_d        = ~dp_act_d[idx_d];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_LAST;
      cnt_q        <= '0;
      val_act_q    <= '0;
      en_act_q     <= '0;
      dp_act_q     <= '0;
      val_pend_q   <= '0;
      en_pend_q    <= '0;
      dp_pend_q    <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      val_act_q    <= val_act_d;
      en_act_q     <= en_act_d;
      dp_act_q     <= dp_act_d;
      val_pend_q   <= val_pend_d;
      en_pend_q    <= en_pend_d;
      dp_pend_q    <= dp_pend_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.An        = an_q;
  assign bus.Seg       = seg_q;
  assign bus.Dp        = dp_q;
  assign bus.LoadAck   = load_ack_q;
  assign bus.FrameDone = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: drives a default build (16 blank cycles) and a no-blank
// build with identical stimulus and compares both against a frame-level model.
module tb_seven_seg_scanner;
  localparam int D = 8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seven_seg_scanner_if #(.DIGITS(D)) bus_a ();
  seven_seg_scanner_if #(.DIGITS(D)) bus_b ();

  seven_seg_scanner #(.DIGITS(D), .BLANK_CYCLES(16), .BLANK_W(5)) dut_a (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_a)
  );

  seven_seg_scanner #(.DIGITS(D), .BLANK_CYCLES(0), .BLANK_W(5)) dut_b (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment patterns, index = hex digit.
  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: ticks counted since reset, edge number of the last tick, data buffers.
  int          tick_count;
  int          last_tick;
  int          cyc;
  logic [31:0] act_val,  pend_val;
  logic [7:0]  act_en,   pend_en;
  logic [7:0]  act_dp,   pend_dp;
  bit          pend_valid;
  bit          exp_ack;
  bit          exp_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    tick_count = 0;
    last_tick  = 0;
    cyc        = 0;
    act_val = '0; act_en = '0; act_dp = '0;
    pend_val = '0; pend_en = '0; pend_dp = '0;
    pend_valid = 0;
    exp_ack = 0;
    exp_fd  = 0;
  endtask

  // Display expected after the latest edge for a build with the given blank length.
  task automatic exp_outputs(input int blank, output logic [7:0] an,
                             output logic [6:0] seg, output logic dp);
    int idx;
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    if (tick_count > 0 && (cyc - last_tick) >= blank) begin
      idx = (tick_count - 1) % D;
      if (act_en[idx]) an[idx] = 1'b0;
      seg = seg_ref[act_val[4*idx +: 4]];
      dp  = ~act_dp[idx];
    end
  endtask

  task automatic compare_all();
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    exp_outputs(16, an, seg, dp);
    check("a_an",  {24'd0, bus_a.An},  {24'd0, an});
    check("a_seg", {25'd0, bus_a.Seg}, {25'd0, seg});
    check("a_dp",  {31'd0, bus_a.Dp},  {31'd0, dp});
    check("a_ack", {31'd0, bus_a.LoadAck},   {31'd0, exp_ack});
    check("a_fd",  {31'd0, bus_a.FrameDone}, {31'd0, exp_fd});
    exp_outputs(0, an, seg, dp);
    check("b_an",  {24'd0, bus_b.An},  {24'd0, an});
    check("b_seg", {25'd0, bus_b.Seg}, {25'd0, seg});
    check("b_dp",  {31'd0, bus_b.Dp},  {31'd0, dp});
    check("b_ack", {31'd0, bus_b.LoadAck},   {31'd0, exp_ack});
    check("b_fd",  {31'd0, bus_b.FrameDone}, {31'd0, exp_fd});
  endtask

  task automatic drive(input bit tk, input bit ld, input logic [31:0] v,
                       input logic [7:0] en, input logic [7:0] dpm);
    bus_a.Tick = tk;  bus_a.Load = ld;  bus_a.Value = v;  bus_a.DigitEn = en;  bus_a.DpMask = dpm;
    bus_b.Tick = tk;  bus_b.Load = ld;  bus_b.Value = v;  bus_b.DigitEn = en;  bus_b.DpMask = dpm;
  endtask

  // One clock: apply inputs, advance the model for that edge, check #1 later.
  task automatic step(input bit tk, input bit ld, input logic [31:0] v,
                      input logic [7:0] en, input logic [7:0] dpm);
    bit wrap;
    drive(tk, ld, v, en, dpm);
    @(posedge clk);
    cyc++;
    wrap    = tk && ((tick_count % D) == 0);
    exp_fd  = wrap;
    exp_ack = wrap && pend_valid;
    if (exp_ack) begin
      act_val = pend_val; act_en = pend_en; act_dp = pend_dp;
      pend_valid = 0;
    end
    if (ld) begin
      pend_val = v; pend_en = en; pend_dp = dpm;
      pend_valid = 1;
    end
    if (tk) begin
      tick_count++;
      last_tick = cyc;
    end
    #1;
    drive(1'b0, 1'b0, v, en, dpm);
    compare_all();
    if (tk || ld)
      $display("txn edge=%0d tick=%0d load=%0d value=%h en=%h dp=%h ack=%0d frame=%0d",
               cyc, tk, ld, v, en, dpm, exp_ack, exp_fd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic tick_then(input int gap);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(gap);
  endtask

  task automatic load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpm);
    step(1'b0, 1'b1, v, en, dpm);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Quiet display with no ticks.
    idle(100);

    // First load commits on the first tick (index wraps from the reset value).
    load(32'h89AB_0123, 8'hFF, 8'h01);
    tick_then(20);
    tick_then(20);

    // Walk the rest of the frame and one more wrap.
    for (int i = 0; i < 8; i++) tick_then(18 + (i % 3));

    // Two loads mid-frame: last one wins, committed once at the wrap.
    tick_then(20);
    load(32'h1111_1111, 8'hFF, 8'h00);
    tick_then(20);
    load(32'hFFFF_FFFF, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) tick_then(17);

    // Upper four digits disabled.
    load(32'h7654_3210, 8'h0F, 8'hA5);
    for (int i = 0; i < 10; i++) tick_then(17);

    // Ticks arriving inside the blanking gap restart it.
    tick_then(5);
    tick_then(0);
    tick_then(20);

    // Randomized traffic, including loads on commit edges and ticks in blank.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
           $urandom(), 8'($urandom()), 8'($urandom()));
    end

    // Asynchronous reset while a digit is lit: outputs go dark without an edge.
    tick_then(20);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(32'hCAFE_BEEF, 8'hFF, 8'hF0);
    for (int i = 0; i < 9; i++) tick_then(17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
